// File: rtl/mu0_cpu_delay1.sv
// rtl/mu0_cpu_delay1.sv - multi-cycle MU0 accumulator CPU for a one-cycle-latency RAM
// Define MU0_ILLEGAL_HALT_EN to make opcodes 8-15 halt instead of acting as no-ops.
module mu0_cpu_delay1 (
    input  logic        clk,
    input  logic        rst,
    output logic        running,
    output logic [11:0] address,
    output logic        write,
    output logic        read,
    output logic [15:0] writedata,
    input  logic [15:0] readdata
);
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    state_t      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] ir_q, ir_d;
    logic        running_q, running_d;

    logic [3:0]  opcode;
    logic [11:0] operand;
    logic        is_mem_read;
    logic        is_halt_op;

    assign opcode      = ir_q[15:12];
    assign operand     = ir_q[11:0];
    assign is_mem_read = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB);

`ifdef MU0_ILLEGAL_HALT_EN
    assign is_halt_op = (opcode == OP_STP) || opcode[3];
`else
    assign is_halt_op = (opcode == OP_STP);
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        acc_d     = acc_q;
        ir_d      = ir_q;
        running_d = running_q;
        case (state_q)
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d    = readdata;
                pc_d    = pc_q + 12'd1;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                if (is_halt_op) begin
                    state_d   = ST_HALT;
                    running_d = 1'b0;
                end else if (is_mem_read) begin
                    state_d = ST_WB;
                end else begin
                    // Untaken jumps keep the PC already advanced in DECODE.
                    case (opcode)
                        OP_JMP:  pc_d = operand;
                        OP_JGE:  if (!acc_q[15]) pc_d = operand;
                        OP_JNE:  if (acc_q != 16'h0000) pc_d = operand;
                        default: ;
                    endcase
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                case (opcode)
                    OP_LDA:  acc_d = readdata;
                    OP_ADD:  acc_d = acc_q + readdata;
                    OP_SUB:  acc_d = acc_q - readdata;
                    default: acc_d = acc_q;
                endcase
            end
            ST_HALT: begin
                running_d = 1'b0;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= 12'h000;
            acc_q     <= 16'h0000;
            ir_q      <= 16'h0000;
            running_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            acc_q     <= acc_d;
            ir_q      <= ir_d;
            running_q <= running_d;
        end
    end

    // Strobes are decoded from the registered state; reset suppresses any access in flight.
    always_comb begin
        address = pc_q;
        read    = 1'b0;
        write   = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    read = 1'b1;
                end
                ST_EXEC: begin
                    if (is_mem_read) begin
                        address = operand;
                        read    = 1'b1;
                    end else if (opcode == OP_STA) begin
                        address = operand;
                        write   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign writedata = acc_q;
    assign running   = running_q;
endmodule

// File: tb/tb_mu0_cpu_delay1.sv
// tb/tb_mu0_cpu_delay1.sv - randomized and directed programs checked against an ISA-level model
module tb_mu0_cpu_delay1;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        running;
    logic [11:0] address;
    logic        write;
    logic        read;
    logic [15:0] writedata;
    logic [15:0] readdata = 16'h0000;
    logic        load_req = 1'b0;

`ifdef MU0_ILLEGAL_HALT_EN
    localparam bit ILLEGAL_HALT = 1'b1;
`else
    localparam bit ILLEGAL_HALT = 1'b0;
`endif
    localparam int MAX_INSTR  = 500;
    localparam int MAX_CYCLES = 3000;

    logic [15:0] ram     [4096];
    logic [15:0] img     [4096];
    logic [15:0] mdl_mem [4096];
    logic [63:0] exp_q[$];
    int          exp_halt;
    int          dut_halt;
    int          vectors = 0;
    int          miscompares = 0;

    mu0_cpu_delay1 dut (
        .clk       (clk),
        .rst       (rst),
        .running   (running),
        .address   (address),
        .write     (write),
        .read      (read),
        .writedata (writedata),
        .readdata  (readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 4096; i++) ram[i] <= img[i];
        end else begin
            if (write) ram[address] <= writedata;
            if (read)  readdata <= ram[address];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ev(input int c, input bit w, input logic [11:0] a,
                                       input logic [15:0] d);
        return {c[31:0], 3'b000, w, a, d};
    endfunction

    task automatic clear_img();
        for (int i = 0; i < 4096; i++) img[i] = 16'h0000;
    endtask

    task automatic load_image();
        @(posedge clk); #1 load_req = 1'b1;
        @(posedge clk); #1 load_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // Instruction-level interpreter producing the expected access trace and halt cycle.
    task automatic model_run();
        logic [11:0] pc;
        logic [15:0] acc;
        logic [15:0] ir;
        logic [3:0]  op;
        logic [11:0] s;
        int          cyc;
        bit          done;
        for (int i = 0; i < 4096; i++) mdl_mem[i] = img[i];
        exp_q.delete();
        exp_halt = -1;
        pc = 12'h000; acc = 16'h0000; cyc = 0; done = 1'b0;
        for (int n = 0; n < MAX_INSTR && !done; n++) begin
            exp_q.push_back(ev(cyc, 1'b0, pc, 16'h0000));
            ir = mdl_mem[pc];
            pc = pc + 12'd1;
            op = ir[15:12];
            s  = ir[11:0];
            if (op == 4'd7 || (ILLEGAL_HALT && op >= 4'd8)) begin
                exp_halt = cyc + 3;
                done = 1'b1;
            end else begin
                case (op)
                    4'd0: begin exp_q.push_back(ev(cyc + 2, 1'b0, s, 16'h0)); acc = mdl_mem[s]; cyc += 4; end
                    4'd1: begin exp_q.push_back(ev(cyc + 2, 1'b1, s, acc)); mdl_mem[s] = acc; cyc += 3; end
                    4'd2: begin exp_q.push_back(ev(cyc + 2, 1'b0, s, 16'h0)); acc = acc + mdl_mem[s]; cyc += 4; end
                    4'd3: begin exp_q.push_back(ev(cyc + 2, 1'b0, s, 16'h0)); acc = acc - mdl_mem[s]; cyc += 4; end
                    4'd4: begin pc = s; cyc += 3; end
                    4'd5: begin if (!acc[15]) pc = s; cyc += 3; end
                    4'd6: begin if (acc != 16'h0000) pc = s; cyc += 3; end
                    default: cyc += 3;
                endcase
            end
        end
    endtask

    task automatic run_dut(input int max_cycles);
        logic [63:0] obs;
        dut_halt = -1;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("first_running", 64'(running), 64'd1);
                check("first_read", 64'(read), 64'd1);
                check("first_addr", 64'(address), 64'd0);
            end
            if (read || write) begin
                obs = ev(c, write, address, write ? writedata : 16'h0000);
                if (exp_q.size() == 0) check("unexpected_access", obs, 64'd0);
                else check("access", obs, exp_q.pop_front());
            end
            if (!running && dut_halt < 0) dut_halt = c;
            if (dut_halt >= 0 && c >= dut_halt + 3) break;
        end
    endtask

    task automatic finish_checks();
        int diffs;
        diffs = 0;
        check("halt_cycle", 64'(dut_halt), 64'(exp_halt));
        check("events_left", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 4096; i++) if (ram[i] !== mdl_mem[i]) diffs++;
        check("mem_image", 64'(diffs), 64'd0);
    endtask

    task automatic run_prog();
        load_image();
        model_run();
        do_reset();
        run_dut(MAX_CYCLES);
        finish_checks();
    endtask

    initial begin
        // Countdown loop
        clear_img();
        img[0] = 16'h0005; img[1] = 16'h3006; img[2] = 16'h6001; img[3] = 16'h1007;
        img[4] = 16'h7000; img[5] = 16'h0003; img[6] = 16'h0001; img[7] = 16'h5555;
        run_prog();
        check("cd_mem7", 64'(ram[7]), 64'h0000);
        check("cd_halt", 64'(dut_halt), 64'd31);

        // Signed wrap: JGE must fall through to the SUB path
        clear_img();
        img[0] = 16'h0010; img[1] = 16'h2011; img[2] = 16'h5007; img[3] = 16'h1012;
        img[4] = 16'h3013; img[5] = 16'h1014; img[6] = 16'h7000; img[7] = 16'h0015;
        img[8] = 16'h1012; img[9] = 16'h7000;
        img[16'h10] = 16'h7FFF; img[16'h11] = 16'h0001; img[16'h12] = 16'h1111;
        img[16'h13] = 16'h8000; img[16'h14] = 16'hFFFF; img[16'h15] = 16'hDEAD;
        run_prog();
        check("wrap_add", 64'(ram[16'h12]), 64'h8000);
        check("wrap_sub", 64'(ram[16'h14]), 64'h0000);

        // JNE untaken at ACC=0, JMP to 0xFFF, PC wraps to 0
        clear_img();
        img[0] = 16'h6005; img[1] = 16'h4FFF; img[2] = 16'h1020; img[5] = 16'h7000;
        img[4095] = 16'h0005;
        run_prog();
        check("branch_halt", 64'(dut_halt), 64'd16);

        // Illegal opcode followed by STP
        clear_img();
        img[0] = 16'h8000; img[1] = 16'h7000;
        run_prog();
        check("illegal_halt", 64'(dut_halt), ILLEGAL_HALT ? 64'd3 : 64'd6);

        // Reset during WB of the second ADD, then reset from HALT
        clear_img();
        img[0] = 16'h2010; img[1] = 16'h2010; img[2] = 16'h1012; img[3] = 16'h7000;
        img[16'h10] = 16'h1234; img[16'h12] = 16'hBEEF;
        load_image();
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            if (c == 7) rst = 1'b1;
        end
        @(posedge clk); #1 rst = 1'b0;
        model_run();
        run_dut(MAX_CYCLES);
        finish_checks();
        check("wb_reset_sum", 64'(ram[16'h12]), 64'h2468);
        run_prog();
        check("halt_reset_sum", 64'(ram[16'h12]), 64'h2468);

        // Random forward-branching programs ending in STP
        for (int t = 0; t < 20; t++) begin
            int          n;
            int          k;
            logic [15:0] v;
            clear_img();
            n = $urandom_range(4, 24);
            for (int i = 0; i < n; i++) begin
                k = $urandom_range(0, 9);
                if (k < 4)      img[i] = {4'(k), 12'h800 | 12'($urandom_range(0, 15))};
                else if (k < 7) img[i] = {4'(k), 12'($urandom_range(i + 1, n))};
                else            img[i] = {4'($urandom_range(8, 15)), 12'($urandom_range(0, 4095))};
            end
            img[n] = 16'h7000;
            for (int j = 0; j < 16; j++) begin
                v = 16'($urandom);
                case ($urandom_range(0, 5))
                    0: v = 16'h7FFF;
                    1: v = 16'h8000;
                    2: v = 16'h0000;
                    default: ;
                endcase
                img[12'h800 + j] = v;
            end
            run_prog();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
